// File: rtl/stopwatch_core_param_if.sv
// Control, status and display signals of the stopwatch core, bundled so the
// core and whatever drives it share one definition of the port widths.
interface stopwatch_core_param_if #(
  parameter int NUM_DIGITS = 5
);
  logic                    start;
  logic                    pause;
  logic                    conti;
  logic                    lap;
  logic                    mode_down;
  logic [4*NUM_DIGITS-1:0] preset;
  logic [NUM_DIGITS:0]     scan_sel;
  logic [7:0]              seg;
  logic [4*NUM_DIGITS-1:0] count_bcd;
  logic                    running;
  logic                    done;

  modport master (
    output start, pause, conti, lap, mode_down, preset,
    input  scan_sel, seg, count_bcd, running, done
  );

  modport slave (
    input  start, pause, conti, lap, mode_down, preset,
    output scan_sel, seg, count_bcd, running, done
  );
endinterface

// File: rtl/stopwatch_core_param.sv
// Stopwatch / countdown timer counting NUM_DIGITS BCD digits, one step per
// TICK_DIV clocks, with pause/continue, lap freeze and a multiplexed
// seven-segment driver. Everything runs on clk; dividers only make enables.
module stopwatch_core_param #(
  parameter int          NUM_DIGITS   = 5,
  parameter int          TICK_DIV     = 1000000,
  parameter int          SCAN_DIV     = 10000,
  parameter logic [7:0]  PREFIX_GLYPH = 8'b10110110,
  parameter int          DP_POS       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  stopwatch_core_param_if.slave  sw
);

  localparam int CW      = 4 * NUM_DIGITS;
  localparam int SEL_W   = NUM_DIGITS + 1;
  localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SCAN_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int POS_W   = $clog2(NUM_DIGITS + 1);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [POS_W-1:0]   POS_MAX   = POS_W'(NUM_DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       count, count_n;
  logic [CW-1:0]       lap_reg, lap_reg_n;
  logic                lap_hold, lap_hold_n;
  logic                mode_r, mode_n;
  logic [PRESC_W-1:0]  presc, presc_n;
  logic                running_r, done_r;
  logic [SCAN_W-1:0]   scan_cnt, scan_cnt_n;
  logic [POS_W-1:0]    pos, pos_n;
  logic [SEL_W-1:0]    scan_sel_r, scan_sel_n;
  logic [7:0]          seg_r, seg_n;
  logic [CW-1:0]       disp;
  logic [7:0]          glyph;

  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (carry) begin
        if (v[4*d +: 4] >= 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (borrow) begin
        if (v[4*d +: 4] == 4'd0) begin
          r[4*d +: 4] = 4'd9;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] bcd_clamp(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (v[4*d +: 4] > 4'd9) r[4*d +: 4] = 4'd9;
    end
    return r;
  endfunction

  function automatic logic [7:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hFC;
      4'd1:    return 8'h60;
      4'd2:    return 8'hDA;
      4'd3:    return 8'hF2;
      4'd4:    return 8'h66;
      4'd5:    return 8'hB6;
      4'd6:    return 8'hBE;
      4'd7:    return 8'hE0;
      4'd8:    return 8'hFE;
      4'd9:    return 8'hF6;
      default: return 8'hFF;
    endcase
  endfunction

  // Next state of the timer: start beats pause beats conti, ticks step the count.
  always_comb begin
    state_n    = state;
    count_n    = count;
    presc_n    = presc;
    lap_hold_n = lap_hold;
    lap_reg_n  = lap_reg;
    mode_n     = mode_r;
    if (sw.start) begin
      mode_n     = sw.mode_down;
      presc_n    = '0;
      lap_hold_n = 1'b0;
      if (sw.mode_down) begin
        count_n = bcd_clamp(sw.preset);
        state_n = (count_n == '0) ? S_DONE : S_RUN;
      end else begin
        count_n = '0;
        state_n = S_RUN;
      end
    end else begin
      case (state)
        S_RUN: begin
          if (sw.pause) begin
            state_n = S_PAUSED;
          end else if (presc == PRESC_MAX) begin
            presc_n = '0;
            if (mode_r) begin
              count_n = bcd_dec(count);
              if (count_n == '0) state_n = S_DONE;
            end else begin
              count_n = bcd_inc(count);
            end
          end else begin
            presc_n = presc + PRESC_W'(1);
          end
        end
        S_PAUSED: begin
          if (sw.conti && !sw.pause) state_n = S_RUN;
        end
        default: begin
        end
      endcase
      if (sw.lap && (state == S_RUN || state == S_PAUSED)) begin
        lap_hold_n = ~lap_hold;
        if (!lap_hold) lap_reg_n = count_n;
      end
    end
  end

  // Timer state, count and lap registers plus the registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      presc     <= '0;
      lap_hold  <= 1'b0;
      lap_reg   <= '0;
      mode_r    <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      presc     <= presc_n;
      lap_hold  <= lap_hold_n;
      lap_reg   <= lap_reg_n;
      mode_r    <= mode_n;
      running_r <= (state_n == S_RUN);
      done_r    <= (state_n == S_DONE);
    end
  end

  // Scan divider: on each wrap move to the next position and latch its glyph.
  always_comb begin
    disp       = lap_hold ? lap_reg : count;
    scan_cnt_n = scan_cnt + SCAN_W'(1);
    pos_n      = pos;
    scan_sel_n = scan_sel_r;
    seg_n      = seg_r;
    glyph      = 8'h00;
    if (scan_cnt == SCAN_MAX) begin
      scan_cnt_n = '0;
      pos_n      = (pos == POS_MAX) ? '0 : pos + POS_W'(1);
      scan_sel_n = SEL_W'(1) << pos_n;
      seg_n      = PREFIX_GLYPH;
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (pos_n == POS_W'(d + 1)) begin
          glyph = decode(disp[4*d +: 4]);
          seg_n = {glyph[7:1], glyph[0] | (d == DP_POS)};
        end
      end
    end
  end

  // Display scan registers; free-running regardless of the timer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt   <= '0;
      pos        <= '0;
      scan_sel_r <= SEL_W'(1);
      seg_r      <= PREFIX_GLYPH;
    end else begin
      scan_cnt   <= scan_cnt_n;
      pos        <= pos_n;
      scan_sel_r <= scan_sel_n;
      seg_r      <= seg_n;
    end
  end

  assign sw.count_bcd = count;
  assign sw.running   = running_r;
  assign sw.done      = done_r;
  assign sw.scan_sel  = scan_sel_r;
  assign sw.seg       = seg_r;

endmodule
